data_cache_arbiter: RTL and testbench

- Shares the single-port data cache BRAM (2-cycle HIGH_PERFORMANCE read) among NUM_REQ requesters: the program controller (requester 0) and the compute cores.
- Round-robin grant with a per-requester valid/ready handshake; registered cache drive; read data returned tagged to the issuing requester.
- Sits between controller/cores and the data cache instance.

---
 rtl/data_cache_arbiter.sv | 155 +++++++++++++++
 tb/tb_data_cache_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_arbiter.sv
// Round-robin arbiter sharing the single-port data cache BRAM among NUM_REQ requesters (0 = controller).
// Latency: grant is combinational; cache drive is registered (+1); read data returns 1+READ_LATENCY cycles after the grant.
// Backpressure: a requester waits with valid held until its ready bit asserts; one access is issued per cycle, with no bubbles.
//
// Ports: clk_in/rst_n_in (async active-low); req_valid_in/req_write_in/req_addr_in/req_wdata_in per requester (packed);
//        req_ready_out one-hot grant; rsp_valid_out one-hot read valid with shared rsp_data_out;
//        cache_en_out/cache_we_out/cache_addr_out/cache_din_out drive the BRAM, cache_dout_in returns its data;
//        busy_out flags an issued access or an outstanding read.
// Optional macro DATA_CACHE_ARB_CTRL_PRIORITY_EN: requester 0 gets fixed top priority; the others rotate among themselves.
module data_cache_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic [NUM_REQ-1:0]               req_valid_in,
    input  logic [NUM_REQ-1:0]               req_write_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata_in,
    output logic [NUM_REQ-1:0]               req_ready_out,
    output logic [NUM_REQ-1:0]               rsp_valid_out,
    output logic [DATA_WIDTH-1:0]            rsp_data_out,
    output logic                             cache_en_out,
    output logic                             cache_we_out,
    output logic [ADDR_WIDTH-1:0]            cache_addr_out,
    output logic [DATA_WIDTH-1:0]            cache_din_out,
    input  logic [DATA_WIDTH-1:0]            cache_dout_in,
    output logic                             busy_out
);

    localparam int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TAG_DEPTH = 1 + READ_LATENCY;

    logic [PTR_W-1:0]      r_rr_ptr;
    logic                  r_en;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic [TAG_DEPTH-1:0]  r_tag_vld;
    logic [PTR_W-1:0]      r_tag_id [TAG_DEPTH];

    logic [NUM_REQ-1:0]    w_grant;
    logic [PTR_W-1:0]      w_grant_idx;
    logic [PTR_W-1:0]      w_cand;
    logic                  w_found;
    logic                  w_xfer;
    logic                  w_sel_write;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [NUM_REQ-1:0]    w_rsp_vld;

    // Arbitration: scan candidates starting one past the last winner, wrapping.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_cand      = '0;
        w_found     = 1'b0;
`ifdef DATA_CACHE_ARB_CTRL_PRIORITY_EN
        // Controller pre-empts everyone; the pointer only ever holds 1..NUM_REQ-1.
        if (req_valid_in[0]) begin
            w_grant[0] = 1'b1;
            w_found    = 1'b1;
        end
        for (int k = 1; k < NUM_REQ; k++) begin
            w_cand = PTR_W'(((int'(r_rr_ptr) - 1 + k) % (NUM_REQ - 1)) + 1);
            if (!w_found && req_valid_in[w_cand]) begin
                w_grant[w_cand] = 1'b1;
                w_grant_idx     = w_cand;
                w_found         = 1'b1;
            end
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid_in[w_cand]) begin
                w_grant[w_cand] = 1'b1;
                w_grant_idx     = w_cand;
                w_found         = 1'b1;
            end
        end
`endif
    end

    // Ready is masked during reset so every output reads 0 while rst_n_in is low.
    assign req_ready_out = w_grant & {NUM_REQ{rst_n_in}};
    assign w_xfer        = |req_ready_out;

    // Steer the winner's command onto the cache drive.
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_write = req_write_in[i];
                w_sel_addr  = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = req_wdata_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rr_ptr  <= PTR_W'(NUM_REQ - 1);
            r_en      <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_din     <= '0;
            r_tag_vld <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_en <= w_xfer;
            r_we <= w_xfer & w_sel_write;
            // Address and data hold between accesses to avoid needless toggling.
            if (w_xfer) begin
                r_addr <= w_sel_addr;
                r_din  <= w_sel_wdata;
`ifdef DATA_CACHE_ARB_CTRL_PRIORITY_EN
                if (w_grant_idx != '0) begin
                    r_rr_ptr <= w_grant_idx;
                end
`else
                r_rr_ptr <= w_grant_idx;
`endif
            end
            // Tag pipeline spans the issue register plus the BRAM read latency.
            r_tag_vld   <= {r_tag_vld[TAG_DEPTH-2:0], w_xfer & ~w_sel_write};
            r_tag_id[0] <= w_grant_idx;
            for (int i = TAG_DEPTH - 1; i > 0; i--) begin
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    always_comb begin
        w_rsp_vld = '0;
        if (r_tag_vld[TAG_DEPTH-1]) begin
            w_rsp_vld[r_tag_id[TAG_DEPTH-1]] = 1'b1;
        end
    end

    assign rsp_valid_out  = w_rsp_vld;
    // BRAM data passes straight through; zeroed when no response so reset leaves outputs at 0.
    assign rsp_data_out   = r_tag_vld[TAG_DEPTH-1] ? cache_dout_in : '0;
    assign cache_en_out   = r_en;
    assign cache_we_out   = r_we;
    assign cache_addr_out = r_addr;
    assign cache_din_out  = r_din;
    assign busy_out       = (|r_tag_vld) | r_en;

endmodule

// File: tb/tb_data_cache_arbiter.sv
module tb_data_cache_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 16;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic [N-1:0]      req_valid_in;
    logic [N-1:0]      req_write_in;
    logic [N*AW-1:0]   req_addr_in;
    logic [N*DW-1:0]   req_wdata_in;
    logic [N-1:0]      req_ready_out;
    logic [N-1:0]      rsp_valid_out;
    logic [DW-1:0]     rsp_data_out;
    logic              cache_en_out;
    logic              cache_we_out;
    logic [AW-1:0]     cache_addr_out;
    logic [DW-1:0]     cache_din_out;
    logic [DW-1:0]     cache_dout_in;
    logic              busy_out;

    data_cache_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req_valid_in(req_valid_in), .req_write_in(req_write_in),
        .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
        .req_ready_out(req_ready_out), .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out),
        .cache_en_out(cache_en_out), .cache_we_out(cache_we_out),
        .cache_addr_out(cache_addr_out), .cache_din_out(cache_din_out),
        .cache_dout_in(cache_dout_in), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Power-up contents of the cache: 0x010 holds 0x1234, everything else addr+0x100.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 12'h010) ? 16'h1234 : 16'(a + 12'h100);
    endfunction

    // Single-port read-first BRAM with a 2-cycle read (input register + output register).
    logic [DW-1:0] bram    [0:4095];
    bit            written [0:4095];
    logic [DW-1:0] bram_rd1 = '0;
    always @(posedge clk_in) begin
        if (cache_en_out) begin
            bram_rd1 <= written[cache_addr_out] ? bram[cache_addr_out] : init_val(cache_addr_out);
            if (cache_we_out) begin
                bram[cache_addr_out]    <= cache_din_out;
                written[cache_addr_out] <= 1'b1;
            end
        end
        cache_dout_in <= bram_rd1;
    end

    // Requester stimulus: each requester holds its command until granted.
    logic          p_vld  [N];
    logic          p_we   [N];
    logic [AW-1:0] p_addr [N];
    logic [DW-1:0] p_wd   [N];

    // Reference model: sequential memory, last winner, expected response list.
    typedef struct { int due; int id; logic [DW-1:0] d; } rsp_t;
    rsp_t          rq [$];
    logic [DW-1:0] ref_mem [0:4095];
    int            last_g;
    int            cyc;
    logic          en_exp, we_exp;
    logic [AW-1:0] addr_exp;
    logic [DW-1:0] din_exp;

    int vec = 0;
    int mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        assert (got === exp) else begin
            mis++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid_in[i]             = p_vld[i];
            req_write_in[i]             = p_we[i];
            req_addr_in[i*AW +: AW]     = p_addr[i];
            req_wdata_in[i*DW +: DW]    = p_wd[i];
        end
    endtask

    // Winner according to the arbitration rules: walk forward from the last winner.
    function automatic int exp_grant();
        int i;
`ifdef DATA_CACHE_ARB_CTRL_PRIORITY_EN
        if (p_vld[0]) return 0;
        i = last_g;
        repeat (N - 1) begin
            i = (i == N - 1) ? 1 : i + 1;
            if (p_vld[i]) return i;
        end
`else
        i = last_g;
        repeat (N) begin
            i = (i + 1) % N;
            if (p_vld[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        rq.delete();
        last_g   = N - 1;
        en_exp   = 1'b0;
        we_exp   = 1'b0;
        addr_exp = '0;
        din_exp  = '0;
    endtask

    // One clock cycle: check at the falling edge, advance the model, step to just past the rising edge.
    task automatic tick(output int g);
        logic busy_exp;
        @(negedge clk_in);
        g = exp_grant();
        chk("ready", 32'(req_ready_out), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("cache_en", 32'(cache_en_out), 32'(en_exp));
        chk("cache_we", 32'(cache_we_out), 32'(we_exp));
        chk("cache_addr", 32'(cache_addr_out), 32'(addr_exp));
        chk("cache_din", 32'(cache_din_out), 32'(din_exp));
        busy_exp = en_exp | (rq.size() > 0);
        chk("busy", 32'(busy_out), 32'(busy_exp));
        if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("rsp_valid", 32'(rsp_valid_out), 32'd1 << rq[0].id);
            chk("rsp_data", 32'(rsp_data_out), 32'(rq[0].d));
            void'(rq.pop_front());
        end else begin
            chk("rsp_idle", 32'(rsp_valid_out), 32'd0);
        end
        en_exp = (g >= 0);
        we_exp = (g >= 0) && p_we[g];
        if (g >= 0) begin
            addr_exp = p_addr[g];
            din_exp  = p_wd[g];
            if (p_we[g]) ref_mem[p_addr[g]] = p_wd[g];
            else         rq.push_back('{due: cyc + 3, id: g, d: ref_mem[p_addr[g]]});
`ifdef DATA_CACHE_ARB_CTRL_PRIORITY_EN
            if (g != 0) last_g = g;
`else
            last_g = g;
`endif
        end
        @(posedge clk_in);
        cyc++;
        #1;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            p_vld[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_wd[i] = '0;
        end
        apply();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready_out), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid_out), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data_out), 32'd0);
        chk({tag, "_en"}, 32'(cache_en_out), 32'd0);
        chk({tag, "_we"}, 32'(cache_we_out), 32'd0);
        chk({tag, "_addr"}, 32'(cache_addr_out), 32'd0);
        chk({tag, "_din"}, 32'(cache_din_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy_out), 32'd0);
    endtask

    initial begin
        int g;
        cyc = 0;
        for (int a = 0; a < 4096; a++) ref_mem[a] = init_val(12'(a));
        model_reset();

        // Reset: outputs 0 even with a requester asserting valid.
        rst_n_in = 1'b0;
        clear_all();
        p_vld[1] = 1'b1;
        apply();
        repeat (3) @(posedge clk_in);
        #1;
        chk_all_zero("reset");
        clear_all();
        rst_n_in = 1'b1;

        // Single read by requester 2 of 0x010.
        p_vld[2] = 1'b1; p_addr[2] = 12'h010;
        apply();
        tick(g);
        clear_all();
        repeat (4) tick(g);

        // All four requesters reading continuously: strict rotation, responses back to back.
        for (int i = 0; i < N; i++) begin
            p_vld[i] = 1'b1; p_addr[i] = 12'(i);
        end
        apply();
        repeat (8) tick(g);
        clear_all();
        repeat (4) tick(g);

        // Write then read-back of the same address by requester 1.
        p_vld[1] = 1'b1; p_we[1] = 1'b1; p_addr[1] = 12'h020; p_wd[1] = 16'hBEEF;
        apply();
        tick(g);
        p_we[1] = 1'b0;
        apply();
        tick(g);
        clear_all();
        repeat (4) tick(g);

        // Reset with two reads in flight.
        p_vld[0] = 1'b1; p_addr[0] = 12'h005;
        p_vld[2] = 1'b1; p_addr[2] = 12'h006;
        apply();
        tick(g);
        tick(g);
        clear_all();
        p_vld[0] = 1'b1; p_addr[0] = 12'h007;
        p_vld[3] = 1'b1; p_addr[3] = 12'h008;
        apply();
        rst_n_in = 1'b0;
        #2;
        chk_all_zero("midreset");
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        cyc++;
        model_reset();
        // Requesters 0 and 3 contend: requester 0 wins first after reset.
        repeat (4) tick(g);
        p_vld[0] = 1'b0;
        apply();
        tick(g);
        clear_all();
        repeat (5) tick(g);

        // Only requester 3 active, then idle so busy drains.
        p_vld[3] = 1'b1; p_addr[3] = 12'h011;
        apply();
        repeat (3) tick(g);
        clear_all();
        repeat (5) tick(g);

        // Randomized traffic over a small address window to exercise read-after-write.
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (!p_vld[i] && ($urandom_range(1, 0) == 1)) begin
                    p_vld[i]  = 1'b1;
                    p_we[i]   = ($urandom_range(2, 0) == 0);
                    p_addr[i] = 12'($urandom_range(15, 0));
                    p_wd[i]   = 16'($urandom);
                end
            end
            apply();
            tick(g);
            if (g >= 0) p_vld[g] = 1'b0;
        end
        clear_all();
        repeat (5) tick(g);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
